uart_rx_phy: RTL and testbench
==============================

Name: uart_rx_phy

Overview:
- Serial receive PHY for the UART: samples the asynchronous line, recovers 8N1 frames and pushes each received byte into a downstream receive FIFO.
- The mirror stage of the transmit path. It consumes the serial stream that the transmit side produces on a peer device.
- Its push/data/full interface connects directly to the push side of fifo_fwft. It shares its bit-timing input with the transmit PHY.

Parameters:
- CLOCKCYCLESPERBITLIMIT, 2: upper bound of clockcyclesperbit_i. The counter width is clog2(CLOCKCYCLESPERBITLIMIT).

Ports:
- clk_i, input, 1: single clock. All logic is on its rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- clockcyclesperbit_i, input, clog2(CLOCKCYCLESPERBITLIMIT): clock cycles per bit (C). Legal range is 2 to CLOCKCYCLESPERBITLIMIT-1.
- rx_i, input, 1: asynchronous serial line. Idle level is high.
- push_o, output, 1: one-cycle strobe carrying a valid received byte.
- data_o, output, 8: received byte. Valid while push_o is high and held until the next push.
- full_i, input, 1: the downstream FIFO is full.
- frmerr_o, output, 1: one-cycle pulse on a framing error.
- ovrrun_o, output, 1: one-cycle pulse when a byte is dropped because full_i is high.

Behaviour:
- Reset values:
  - push_o, frmerr_o, ovrrun_o = 0; data_o = 8'h00.
  - State = IDLE; counters = 0.
  - Synchronizer flops = 1 (line idle).
- Synchronizer: 2-flop synchronizer on rx_i produces rx_s. All decisions use rx_s only.
- C handling:
  - C is latched when the start bit is detected.
  - Changes to clockcyclesperbit_i mid-frame have no effect until the next frame.
- States:
  - IDLE: on rx_s==0, latch C, load cnt=(C>>1)-1, go to START.
  - START: count down cnt to 0 (mid start bit), then sample rx_s.
    - rx_s==1: glitch; return to IDLE with no outputs.
    - rx_s==0: load cnt=C-1, bitidx=0, go to DATA.
  - DATA: at cnt==0, shift rx_s into the shift register LSB-first and reload cnt=C-1. After bitidx 7, go to STOP.
  - STOP: at cnt==0, sample rx_s.
    - rx_s==1 and full_i==0: next cycle push_o=1 and data_o=byte; go to IDLE.
    - rx_s==1 and full_i==1: next cycle ovrrun_o=1, no push, data_o unchanged; go to IDLE.
    - rx_s==0: next cycle frmerr_o=1, no push; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frmerr_o.
- Latency: push_o is high exactly 9*C + C/2 + 3 cycles after the falling edge on rx_i. That is 2 synchronizer cycles plus 1 output register cycle.
- full_i is sampled only at the stop-bit sample cycle.
- push_o, frmerr_o and ovrrun_o are mutually exclusive and never high for two consecutive cycles.
- Back-to-back frames: a start bit that begins immediately after the stop bit's sample point is detected correctly. IDLE is re-entered before the stop bit ends.
- rst_i mid-frame: the partial byte is discarded and no strobe is issued. A frame already in progress on the line is resynchronised at the next high-to-low transition seen from IDLE.

Optional Feature:
- Macro: UART_RX_PHY_GLITCHFILTER_EN.
- Defined:
  - A 3-tap shift register follows the synchronizer.
  - The decision signal is the majority of the 3 taps, replacing rx_s.
  - Adds 1 cycle, so latency becomes 9*C + C/2 + 4.
  - Single-cycle pulses on the line are rejected.
- Undefined: rx_s is used directly, with the latency stated above.

Decomposition:
- Shared package/include:
  - State encodings: IDLE, START, DATA, STOP, BREAK.
  - Frame constants: DATABITS=8, STOPBITS=1.
- Sub-module uart_rx_sync: 2-flop synchronizer plus the optional majority filter. Output is the decision signal.
- The FSM, counters and shift register stay in uart_rx_phy.

Test Plan:
1. Normal byte: C=8, full_i=0, send 0xA5 as 8N1 with the falling edge at cycle 0 -> push_o high only at cycle 79, data_o=8'hA5, no error pulses.
2. Back-to-back: C=16, bytes 0x00, 0xFF, 0x55 with no idle gap -> three push_o pulses with those values in order, spaced 160 cycles apart.
3. Framing error: C=8, send 0x3C with the stop bit held low for 3 bit times, then idle -> frmerr_o exactly once at cycle 79, no push_o; a following byte 0x12 is received correctly.
4. Overrun: C=8, full_i=1 during the stop-bit sample of 0x77 -> ovrrun_o at cycle 79, no push_o, data_o keeps its previous value.
5. Glitch/reset:
   - C=8, rx_i low for 2 cycles only -> no strobes and the FSM returns to IDLE.
   - rst_i asserted during bit 4 of 0x81 -> no strobe for that frame, all outputs at reset values, the next frame 0x42 is received.
6. Baud change: drive clockcyclesperbit_i from 8 to 4 in the middle of byte 0x99 -> that byte is received at C=8 and the next byte 0x66 at C=4, both correct.

Source files
------------

// File: rtl/uart_rx_phy_pkg.sv
// uart_rx_phy_pkg
//   Shared definitions for the UART receive PHY: FSM state encoding and
//   8N1 frame constants. Imported by uart_rx_sync and uart_rx_phy.
//   Optional feature macro used by this slice: UART_RX_PHY_GLITCHFILTER_EN.
package uart_rx_phy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATABITS = 8;
  localparam int unsigned STOPBITS = 1;
  localparam int unsigned BITIDX_W = $clog2(DATABITS);

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous serial line into clk_i and produces the single
//   decision signal the receive FSM acts on.
//   Macro UART_RX_PHY_GLITCHFILTER_EN: when defined, a majority vote over a
//   3-tap shift chain (synchronizer output plus two delayed copies) replaces
//   the raw synchronizer output. This adds one cycle of latency and rejects
//   single-cycle pulses on the line.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset; all flops reset to 1 (line idle)
//   rx_i   - asynchronous serial line
//   rx_o   - synchronised (optionally filtered) decision signal
module uart_rx_sync
  import uart_rx_phy_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

`ifdef UART_RX_PHY_GLITCHFILTER_EN
  // Taps are sync_q[1] and its two delayed copies, so a level change wins
  // the vote one cycle after it leaves the synchronizer.
  logic [1:0] dly_q;
  logic [2:0] taps;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q <= 2'b11;
    end else begin
      dly_q <= {dly_q[0], sync_q[1]};
    end
  end

  assign taps = {dly_q, sync_q[1]};
  assign rx_o = (taps[0] & taps[1]) | (taps[1] & taps[2]) | (taps[0] & taps[2]);
`else
  assign rx_o = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx_phy.sv
// uart_rx_phy
//   Serial receive PHY: recovers 8N1 frames from the line and pushes each
//   byte into a downstream first-word-fall-through FIFO.
//   Macro UART_RX_PHY_GLITCHFILTER_EN (see uart_rx_sync) adds a majority
//   filter and one cycle of latency; default build uses the plain
//   2-flop synchronizer.
// Ports:
//   clk_i               - clock, rising edge
//   rst_i               - synchronous active-high reset
//   clockcyclesperbit_i - clock cycles per bit C, legal 2..LIMIT-1,
//                         latched at start-bit detection
//   rx_i                - asynchronous serial line, idle high
//   push_o              - one-cycle strobe, data_o valid
//   data_o              - received byte, held until next push
//   full_i              - downstream FIFO full, sampled at stop-bit sample
//   frmerr_o            - one-cycle pulse on framing error
//   ovrrun_o            - one-cycle pulse when a byte is dropped (full_i)
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to the middle of the start bit, then validating it
// DATA  | sampling 8 data bits LSB-first at bit centres
// STOP  | waiting for the stop-bit centre, then push / overrun / frmerr
// BREAK | line held low after a framing error, waiting for it to go high
module uart_rx_phy
  import uart_rx_phy_pkg::*;
#(
  parameter int unsigned CLOCKCYCLESPERBITLIMIT = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [$clog2(CLOCKCYCLESPERBITLIMIT)-1:0] clockcyclesperbit_i,
  input  logic                                      rx_i,
  output logic                                      push_o,
  output logic [7:0]                                data_o,
  input  logic                                      full_i,
  output logic                                      frmerr_o,
  output logic                                      ovrrun_o
);

  localparam int unsigned CW = $clog2(CLOCKCYCLESPERBITLIMIT);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [BITIDX_W-1:0] IDX_ONE  = BITIDX_W'(1);
  localparam logic [BITIDX_W-1:0] LAST_BIT = BITIDX_W'(DATABITS - 1);

  logic                rx_s;
  rx_state_e           state_q;
  logic [CW-1:0]       c_q;
  logic [CW-1:0]       cnt_q;
  logic [BITIDX_W-1:0] bitidx_q;
  logic [7:0]          shift_q;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .rx_o  (rx_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      c_q      <= '0;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_o   <= 8'h00;
      push_o   <= 1'b0;
      frmerr_o <= 1'b0;
      ovrrun_o <= 1'b0;
    end else begin
      push_o   <= 1'b0;
      frmerr_o <= 1'b0;
      ovrrun_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            // C is frozen for the whole frame; half a bit reaches the
            // start-bit centre.
            c_q     <= clockcyclesperbit_i;
            cnt_q   <= (clockcyclesperbit_i >> 1) - CNT_ONE;
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (rx_s) begin
            state_q <= IDLE;
          end else begin
            cnt_q    <= c_q - CNT_ONE;
            bitidx_q <= '0;
            state_q  <= DATA;
          end
        end

        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q   <= c_q - CNT_ONE;
            if (bitidx_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bitidx_q <= bitidx_q + IDX_ONE;
            end
          end
        end

        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (rx_s) begin
            // Returning to IDLE at the stop-bit centre leaves half a bit
            // of margin to catch a back-to-back start edge.
            if (full_i) begin
              ovrrun_o <= 1'b1;
            end else begin
              push_o <= 1'b1;
              data_o <= shift_q;
            end
            state_q <= IDLE;
          end else begin
            frmerr_o <= 1'b1;
            state_q  <= BREAK;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_phy.sv
// tb_uart_rx_phy
//   Directed bench for uart_rx_phy: normal byte, back-to-back frames,
//   framing error, overrun, start glitch, mid-frame reset, baud change.
module tb_uart_rx_phy;
  import uart_rx_phy_pkg::*;

`ifdef UART_RX_PHY_GLITCHFILTER_EN
  localparam int LAT_FIX = 4;
`else
  localparam int LAT_FIX = 3;
`endif

  localparam int EV_PUSH = 1;
  localparam int EV_FRM  = 2;
  localparam int EV_OVR  = 3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] clockcyclesperbit_i = 5'd8;
  logic       rx_i = 1'b1;
  logic       push_o;
  logic [7:0] data_o;
  logic       full_i = 1'b0;
  logic       frmerr_o;
  logic       ovrrun_o;

  uart_rx_phy #(.CLOCKCYCLESPERBITLIMIT(32)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .clockcyclesperbit_i (clockcyclesperbit_i),
    .rx_i                (rx_i),
    .push_o              (push_o),
    .data_o              (data_o),
    .full_i              (full_i),
    .frmerr_o            (frmerr_o),
    .ovrrun_o            (ovrrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t ev_q[$];
  int  excl_viol = 0;
  bit  prev_any  = 1'b0;

  // Record every strobe with the cycle it was seen in; also flag overlap
  // or back-to-back strobes.
  always @(negedge clk_i) begin
    bit any;
    any = push_o | frmerr_o | ovrrun_o;
    if (push_o)   ev_q.push_back('{EV_PUSH, data_o, cyc});
    if (frmerr_o) ev_q.push_back('{EV_FRM, data_o, cyc});
    if (ovrrun_o) ev_q.push_back('{EV_OVR, data_o, cyc});
    if ((int'(push_o) + int'(frmerr_o) + int'(ovrrun_o)) > 1) excl_viol++;
    if (any && prev_any) excl_viol++;
    prev_any = any;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic expect_event(input string tag, input int kind, input logic [7:0] data, input int at);
    ev_t e;
    if (ev_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = ev_q.pop_front();
      chk({tag, "_kind"}, 32'(e.kind), 32'(kind));
      chk({tag, "_cycle"}, 32'(e.at), 32'(at));
      if (kind == EV_PUSH) chk({tag, "_data"}, {24'h0, e.data}, {24'h0, data});
    end
  endtask

  task automatic expect_quiet(input string tag);
    chk(tag, 32'(ev_q.size()), 32'd0);
    ev_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int c, input int stop_bits,
                           input logic stop_lvl, output int t0);
    t0 = cyc;
    rx_i = 1'b0;
    step(c);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      step(c);
    end
    rx_i = stop_lvl;
    step(c * stop_bits);
    rx_i = 1'b1;
  endtask

  int t0, t1, t2;

  initial begin
    // Reset state
    step(3);
    chk("rst_push", 32'(push_o), 32'd0);
    chk("rst_frmerr", 32'(frmerr_o), 32'd0);
    chk("rst_ovrrun", 32'(ovrrun_o), 32'd0);
    chk("rst_data", {24'h0, data_o}, 32'h00);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_i = 1'b0;
    step(5);
    expect_quiet("rst_quiet");

    // 1. Normal byte, C=8: push at t0+79
    clockcyclesperbit_i = 5'd8;
    send_byte(8'hA5, 8, 1, 1'b1, t0);
    step(10);
    expect_event("t1_a5", EV_PUSH, 8'hA5, t0 + 72 + 4 + LAT_FIX);
    expect_quiet("t1_only");
    chk("t1_hold", {24'h0, data_o}, 32'hA5);

    // 2. Back-to-back, C=16: pushes 160 cycles apart
    clockcyclesperbit_i = 5'd16;
    send_byte(8'h00, 16, 1, 1'b1, t0);
    send_byte(8'hFF, 16, 1, 1'b1, t1);
    send_byte(8'h55, 16, 1, 1'b1, t2);
    step(20);
    expect_event("t2_00", EV_PUSH, 8'h00, t0 + 144 + 8 + LAT_FIX);
    expect_event("t2_ff", EV_PUSH, 8'hFF, t0 + 160 + 144 + 8 + LAT_FIX);
    expect_event("t2_55", EV_PUSH, 8'h55, t0 + 320 + 144 + 8 + LAT_FIX);
    expect_quiet("t2_only");

    // 3. Framing error: stop held low 3 bit times, then 0x12
    clockcyclesperbit_i = 5'd8;
    send_byte(8'h3C, 8, 3, 1'b0, t0);
    step(20);
    expect_event("t3_frm", EV_FRM, 8'h00, t0 + 79 + LAT_FIX - 3);
    expect_quiet("t3_once");
    send_byte(8'h12, 8, 1, 1'b1, t0);
    step(10);
    expect_event("t3_12", EV_PUSH, 8'h12, t0 + 79 + LAT_FIX - 3);
    expect_quiet("t3_after");

    // 4. Overrun: full during stop sample of 0x77, data_o keeps 0x12
    full_i = 1'b1;
    send_byte(8'h77, 8, 1, 1'b1, t0);
    step(4);
    full_i = 1'b0;
    step(6);
    expect_event("t4_ovr", EV_OVR, 8'h00, t0 + 79 + LAT_FIX - 3);
    expect_quiet("t4_nopush");
    chk("t4_hold", {24'h0, data_o}, 32'h12);

    // 5a. Two-cycle low glitch: no strobe, FSM back in IDLE
    rx_i = 1'b0;
    step(2);
    rx_i = 1'b1;
    step(30);
    expect_quiet("t5_glitch");
    chk("t5_idle", 32'(dut.state_q), 32'(IDLE));

    // 5b. Reset during bit 4 of 0x81
    rx_i = 1'b0;
    step(8);
    rx_i = 1'b1;               // bit0 of 0x81
    step(8);
    rx_i = 1'b0;               // bits 1..4
    step(27);
    rst_i = 1'b1;
    step(2);
    chk("t5_rst_push", 32'(push_o), 32'd0);
    chk("t5_rst_data", {24'h0, data_o}, 32'h00);
    chk("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_i = 1'b0;
    rx_i = 1'b1;
    step(40);
    expect_quiet("t5_nostrobe");
    send_byte(8'h42, 8, 1, 1'b1, t0);
    step(10);
    expect_event("t5_42", EV_PUSH, 8'h42, t0 + 79 + LAT_FIX - 3);
    expect_quiet("t5_after");

    // 6. Baud change mid-frame: 0x99 at C=8, then 0x66 at C=4
    fork
      send_byte(8'h99, 8, 1, 1'b1, t0);
      begin
        step(40);
        clockcyclesperbit_i = 5'd4;
      end
    join
    step(6);
    send_byte(8'h66, 4, 1, 1'b1, t1);
    step(10);
    expect_event("t6_99", EV_PUSH, 8'h99, t0 + 79 + LAT_FIX - 3);
    expect_event("t6_66", EV_PUSH, 8'h66, t1 + 36 + 2 + LAT_FIX);
    expect_quiet("t6_after");

    chk("excl_strobes", 32'(excl_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
